// File: rtl/regbank_multiport_dbg.sv
// Register bank with two combinational read ports, one synchronous write
// port, optional write-to-read bypass, optional hard-wired zero register and
// a valid/ready dump engine that streams every register to a debug consumer.
module regbank_multiport_dbg #(
  parameter int                   ADDR_BITS   = 5,
  parameter int                   WORD_WIDE   = 32,
  parameter bit                   ZERO_REG    = 1'b1,
  parameter bit                   BYPASS      = 1'b1,
  parameter logic [WORD_WIDE-1:0] RESET_VALUE = '0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 regWrite,
  input  logic [ADDR_BITS-1:0] writeReg,
  input  logic [WORD_WIDE-1:0] writeData,
  input  logic [ADDR_BITS-1:0] readReg1,
  input  logic [ADDR_BITS-1:0] readReg2,
  output logic [WORD_WIDE-1:0] readData1,
  output logic [WORD_WIDE-1:0] readData2,
  input  logic                 dbgStart,
  input  logic                 dbgReady,
  output logic                 dbgValid,
  output logic [ADDR_BITS-1:0] dbgAddr,
  output logic [WORD_WIDE-1:0] dbgData,
  output logic                 dbgLast,
  output logic                 dbgBusy,
  output logic                 dbgDone
);

  localparam int                   DEPTH     = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } dumpState_t;

  logic [WORD_WIDE-1:0] banco [DEPTH];
  logic                 writeEnable;
  logic [WORD_WIDE-1:0] stored1;
  logic [WORD_WIDE-1:0] stored2;

  dumpState_t           state;
  dumpState_t           nextState;
  logic [ADDR_BITS-1:0] ptr;
  logic                 beatAccept;

  // A write aimed at the hard-wired zero register is simply dropped.
  assign writeEnable = regWrite && !(ZERO_REG && (writeReg == '0));
  assign stored1     = banco[readReg1];
  assign stored2     = banco[readReg2];

  // Read mux: zero register wins over bypass, bypass wins over stored value.
  function automatic logic [WORD_WIDE-1:0] selectRead(
    input logic [ADDR_BITS-1:0] addr,
    input logic [WORD_WIDE-1:0] stored
  );
    if (ZERO_REG && (addr == '0))
      return '0;
    if (BYPASS && writeEnable && (writeReg == addr))
      return writeData;
    return stored;
  endfunction

  // Register storage, cleared to RESET_VALUE (zero register to 0).
  // NOTE: the bank is reset because the block must come up with known
  // contents; this forces flops rather than a RAM macro, which is accepted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        banco[i] <= (ZERO_REG && (i == 0)) ? '0 : RESET_VALUE;
    end else if (writeEnable) begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples pre-edge values regardless of block ordering.
      banco[writeReg] <= writeData;
    end
  end

  // Combinational read ports.
  always_comb begin
    readData1 = selectRead(readReg1, stored1);
    readData2 = selectRead(readReg2, stored2);
  end

  // Dump state register and beat pointer; the pointer never wraps.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= nextState;
      if ((state == IDLE) && dbgStart)
        ptr <= '0;
      else if (beatAccept && (ptr != LAST_ADDR))
        ptr <= ptr + 1'b1;
    end
  end

  // Dump next-state and handshake outputs.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    nextState  = state;
    beatAccept = 1'b0;
    dbgValid   = 1'b0;
    dbgBusy    = 1'b0;
    dbgDone    = 1'b0;
    dbgLast    = 1'b0;
    dbgAddr    = '0;
    dbgData    = '0;
    case (state)
      IDLE: begin
        if (dbgStart)
          nextState = STREAM;
      end
      STREAM: begin
        dbgValid   = 1'b1;
        dbgBusy    = 1'b1;
        dbgAddr    = ptr;
        dbgData    = (ZERO_REG && (ptr == '0)) ? '0 : banco[ptr];
        dbgLast    = (ptr == LAST_ADDR);
        beatAccept = dbgReady;
        if (dbgReady && (ptr == LAST_ADDR))
          nextState = DONE;
      end
      DONE: begin
        dbgBusy   = 1'b1;
        dbgDone   = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

endmodule

// File: tb/tb_regbank_multiport_dbg.sv
// Self-checking bench: a bypass and a non-bypass instance share stimulus;
// a behavioural model of the bank and dump sequence is compared every cycle.
module tb_regbank_multiport_dbg;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        regWrite = 1'b0;
  logic [4:0]  writeReg = '0;
  logic [31:0] writeData = '0;
  logic [4:0]  readReg1 = '0;
  logic [4:0]  readReg2 = '0;
  logic        dbgStart = 1'b0;
  logic        dbgReady = 1'b0;

  logic [31:0] readData1, readData2;
  logic        dbgValid, dbgLast, dbgBusy, dbgDone;
  logic [4:0]  dbgAddr;
  logic [31:0] dbgData;

  logic [31:0] nbRead1, nbRead2;
  logic        nbValid, nbLast, nbBusy, nbDone;
  logic [4:0]  nbAddr;
  logic [31:0] nbData;

  int checksTotal  = 0;
  int checksPassed = 0;

  always #5 clock = ~clock;

  regbank_multiport_dbg #(
    .ADDR_BITS(5), .WORD_WIDE(32), .ZERO_REG(1'b1), .BYPASS(1'b1),
    .RESET_VALUE(32'h5A)
  ) dut (
    .clock(clock), .reset(reset), .regWrite(regWrite), .writeReg(writeReg),
    .writeData(writeData), .readReg1(readReg1), .readReg2(readReg2),
    .readData1(readData1), .readData2(readData2), .dbgStart(dbgStart),
    .dbgReady(dbgReady), .dbgValid(dbgValid), .dbgAddr(dbgAddr),
    .dbgData(dbgData), .dbgLast(dbgLast), .dbgBusy(dbgBusy), .dbgDone(dbgDone)
  );

  regbank_multiport_dbg #(
    .ADDR_BITS(5), .WORD_WIDE(32), .ZERO_REG(1'b1), .BYPASS(1'b0),
    .RESET_VALUE(32'h5A)
  ) dutNb (
    .clock(clock), .reset(reset), .regWrite(regWrite), .writeReg(writeReg),
    .writeData(writeData), .readReg1(readReg1), .readReg2(readReg2),
    .readData1(nbRead1), .readData2(nbRead2), .dbgStart(dbgStart),
    .dbgReady(dbgReady), .dbgValid(nbValid), .dbgAddr(nbAddr),
    .dbgData(nbData), .dbgLast(nbLast), .dbgBusy(nbBusy), .dbgDone(nbDone)
  );

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    checksTotal++;
    if (actual === expected)
      checksPassed++;
    else
      $display("FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] mBank [32];
  bit          mStreaming;
  int          mBeat;
  bit          mDone;

  task automatic modelReset();
    for (int i = 0; i < 32; i++)
      mBank[i] = (i == 0) ? 32'h0 : 32'h5A;
    mStreaming = 1'b0;
    mBeat      = 0;
    mDone      = 1'b0;
  endtask

  function automatic logic [31:0] expRead(input logic [4:0] addr, input bit bypass);
    if (addr == 5'd0) return 32'h0;
    if (bypass && regWrite && (writeReg == addr)) return writeData;
    return mBank[addr];
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      modelReset();
    end else begin
      if (mDone)
        mDone = 1'b0;
      else if (mStreaming) begin
        if (dbgReady) begin
          if (mBeat == 31) begin
            mStreaming = 1'b0;
            mDone      = 1'b1;
          end else begin
            mBeat++;
          end
        end
      end else if (dbgStart) begin
        mStreaming = 1'b1;
        mBeat      = 0;
      end
      if (regWrite && (writeReg != 5'd0))
        mBank[writeReg] = writeData;
    end
  end

  // Compare every cycle, on the falling edge.
  always @(negedge clock) begin
    logic [4:0] beatAddr;
    beatAddr = 5'(mBeat);
    check("rd1", readData1, expRead(readReg1, 1'b1));
    check("rd2", readData2, expRead(readReg2, 1'b1));
    check("nb_rd1", nbRead1, expRead(readReg1, 1'b0));
    check("nb_rd2", nbRead2, expRead(readReg2, 1'b0));
    check("dbgValid", {31'd0, dbgValid}, {31'd0, mStreaming});
    check("dbgBusy", {31'd0, dbgBusy}, {31'd0, mStreaming || mDone});
    check("dbgDone", {31'd0, dbgDone}, {31'd0, mDone});
    check("dbgAddr", {27'd0, dbgAddr}, mStreaming ? {27'd0, beatAddr} : 32'h0);
    check("dbgData", dbgData, (mStreaming && beatAddr != 5'd0) ? mBank[beatAddr] : 32'h0);
    check("dbgLast", {31'd0, dbgLast}, {31'd0, mStreaming && (mBeat == 31)});
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // ---------------- directed and random stimulus ----------------
  initial begin
    int beats, lastCyc, doneCyc, busyFall, n;

    #2 reset = 1'b1;
    for (int a = 0; a < 32; a++) begin
      readReg1 = 5'(a);
      readReg2 = 5'(31 - a);
      #1;
      check("rst_rd1", readData1, (a == 0) ? 32'h0 : 32'h5A);
      check("rst_rd2", readData2, (a == 31) ? 32'h0 : 32'h5A);
    end
    check("rst_dbg", {dbgValid, dbgLast, dbgBusy, dbgDone, dbgAddr} | dbgData, 32'h0);
    step();
    reset = 1'b0;

    // Write r7, read it back on both ports.
    regWrite = 1'b1; writeReg = 5'd7; writeData = 32'h12345678;
    step();
    regWrite = 1'b0; readReg1 = 5'd7; readReg2 = 5'd7;
    #1;
    check("r7_p1", readData1, 32'h12345678);
    check("r7_p2", readData2, 32'h12345678);
    check("r7_nb", nbRead1, 32'h12345678);

    // Writes to r0 are dropped and never bypassed.
    regWrite = 1'b1; writeReg = 5'd0; writeData = 32'hFFFF; readReg1 = 5'd0;
    #1;
    check("r0_bypass", readData1, 32'h0);
    step();
    regWrite = 1'b0;
    #1;
    check("r0_after", readData1, 32'h0);

    // Same-cycle bypass vs stored value.
    regWrite = 1'b1; writeReg = 5'd3; writeData = 32'hABCD; readReg1 = 5'd3;
    #1;
    check("bypass_on", readData1, 32'hABCD);
    check("bypass_off", nbRead1, 32'h5A);
    step();
    regWrite = 1'b0;

    // Preload rK = K+100.
    for (int k = 1; k < 32; k++) begin
      regWrite = 1'b1; writeReg = 5'(k); writeData = 32'(k + 100);
      step();
    end
    regWrite = 1'b0;

    // Full dump with dbgReady held high.
    dbgStart = 1'b1; dbgReady = 1'b1;
    step();
    dbgStart = 1'b0;
    beats = 0; lastCyc = -1; doneCyc = -1; busyFall = -1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (dbgValid) begin
        check("dump_addr", {27'd0, dbgAddr}, 32'(beats));
        check("dump_data", dbgData, (beats == 0) ? 32'h0 : 32'(beats + 100));
        check("dump_last", {31'd0, dbgLast}, {31'd0, beats == 31});
        if (dbgLast) lastCyc = cyc;
        beats++;
      end
      if (dbgDone && doneCyc < 0) doneCyc = cyc;
      if (!dbgBusy && doneCyc >= 0 && busyFall < 0) busyFall = cyc;
      step();
    end
    check("dump_beats", 32'(beats), 32'd32);
    check("dump_lastcyc", 32'(lastCyc), 32'd31);
    check("dump_done", 32'(doneCyc), 32'(lastCyc + 1));
    check("dump_busyfall", 32'(busyFall), 32'(doneCyc + 1));

    // Backpressure at beat 5, write during stall, ignored restart.
    dbgStart = 1'b1;
    step();
    dbgStart = 1'b0;
    n = 0;
    while (dbgAddr != 5'd5 && n < 40) begin
      step();
      n++;
    end
    check("reach_beat5", {27'd0, dbgAddr}, 32'd5);
    dbgReady = 1'b0;
    for (int s = 0; s < 3; s++) begin
      check("stall_valid", {31'd0, dbgValid}, 32'd1);
      check("stall_addr", {27'd0, dbgAddr}, 32'd5);
      if (s == 1) begin
        regWrite = 1'b1; writeReg = 5'd5; writeData = 32'h77; dbgStart = 1'b1;
      end
      step();
      regWrite = 1'b0; dbgStart = 1'b0;
    end
    check("stall_data", dbgData, 32'h77);
    check("stall_addr_end", {27'd0, dbgAddr}, 32'd5);
    dbgReady = 1'b1;
    step();
    check("no_restart", {27'd0, dbgAddr}, 32'd6);

    // Reset mid-dump at beat 10.
    n = 0;
    while (dbgAddr != 5'd10 && n < 40) begin
      step();
      n++;
    end
    check("reach_beat10", {27'd0, dbgAddr}, 32'd10);
    #1 reset = 1'b1;
    readReg1 = 5'd5;
    #1;
    check("abort_valid", {31'd0, dbgValid}, 32'd0);
    check("abort_busy", {31'd0, dbgBusy}, 32'd0);
    check("abort_reg", readData1, 32'h5A);
    step();
    step();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("abort_nodone", {31'd0, dbgDone}, 32'd0);
      step();
    end
    dbgStart = 1'b1;
    step();
    dbgStart = 1'b0;
    check("restart_valid", {31'd0, dbgValid}, 32'd1);
    check("restart_addr", {27'd0, dbgAddr}, 32'd0);

    // Randomised traffic, including occasional resets.
    for (int i = 0; i < 3000; i++) begin
      regWrite  = 1'($urandom_range(0, 1));
      writeReg  = 5'($urandom);
      writeData = $urandom;
      readReg1  = ($urandom_range(0, 3) == 0) ? writeReg : 5'($urandom);
      readReg2  = ($urandom_range(0, 3) == 0) ? writeReg : 5'($urandom);
      dbgStart  = ($urandom_range(0, 15) == 0);
      dbgReady  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 599) == 0) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
      end else begin
        step();
      end
    end

    @(posedge clock);
    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule

// File: doc/regbank_multiport_dbg.md
Name: regbank_multiport_dbg

Overview:
- Parametrised successor to the datapath register bank.
- Holds 2^ADDR_BITS registers of WORD_WIDE bits, with two combinational read ports and one synchronous write port.
- Optional write-to-read bypass and optional hard-wired zero register.
- Replaces the fixed five-register debug taps with a valid/ready streaming dump engine that walks the whole bank, so the debug unit can send every register out of the UART path.

Parameters:
- ADDR_BITS, 5, register address width; bank depth DEPTH = 2^ADDR_BITS.
- WORD_WIDE, 32, register width in bits.
- ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes.
- BYPASS, 1, 1 = a same-cycle write to the addressed register is forwarded to readData1/readData2.
- RESET_VALUE, 0, value loaded into every register on reset (WORD_WIDE bits).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- regWrite  in  1  write enable.
- writeReg  in  ADDR_BITS  write address.
- writeData  in  WORD_WIDE  write data.
- readReg1  in  ADDR_BITS  read address, port 1.
- readReg2  in  ADDR_BITS  read address, port 2.
- readData1  out  WORD_WIDE  read data, port 1 (combinational).
- readData2  out  WORD_WIDE  read data, port 2 (combinational).
- dbgStart  in  1  request a full-bank dump; sampled in IDLE only.
- dbgReady  in  1  debug consumer accepts the current beat.
- dbgValid  out  1  dump beat valid.
- dbgAddr  out  ADDR_BITS  register index of the current beat.
- dbgData  out  WORD_WIDE  register contents of the current beat.
- dbgLast  out  1  current beat is register DEPTH-1.
- dbgBusy  out  1  dump in progress.
- dbgDone  out  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset (asynchronous, active-high):
  - All registers take RESET_VALUE; register 0 takes 0 when ZERO_REG=1.
  - FSM goes to IDLE; the pointer goes to 0.
  - dbgValid, dbgLast, dbgBusy, dbgDone = 0; dbgAddr = 0; dbgData = 0.
  - Reset mid-dump aborts the dump; no dbgDone is issued.
- Write:
  - On the rising clock edge with regWrite=1, banco[writeReg] <= writeData.
  - The write is dropped when ZERO_REG=1 and writeReg=0.
- Read (combinational, zero latency):
  - readDataN = banco[readRegN].
  - BYPASS=1: if regWrite=1 and writeReg==readRegN (and that is not a dropped zero-register write), readDataN = writeData in the same cycle.
  - ZERO_REG=1 and readRegN=0 gives 0 regardless of bypass.
- Dump FSM states: IDLE, STREAM, DONE.
  - IDLE: dbgBusy=0, dbgValid=0. dbgStart=1 sets ptr <= 0 and moves to STREAM on the next edge.
  - STREAM: dbgBusy=1, dbgValid=1, dbgAddr=ptr, dbgData=stored banco[ptr] (no bypass; zero rule applies), dbgLast=(ptr==DEPTH-1).
    - Beat accepted when dbgValid && dbgReady at a rising edge; ptr <= ptr+1.
    - Acceptance with dbgLast=1 moves to DONE.
  - DONE: dbgDone=1 and dbgBusy=1 for exactly one cycle, then IDLE.
- Handshake rules:
  - Once dbgValid=1, it stays high and dbgAddr stays stable until acceptance.
  - dbgData may change during a stall if the pointed register is written; the value at the acceptance edge is the beat value.
  - One beat per cycle maximum. DEPTH beats in DEPTH cycles with dbgReady held high.
- dbgStart while in STREAM or DONE is ignored; it is not queued.
- Normal reads and writes continue during a dump. No wrap-around: the pointer never advances past DEPTH-1.

Test Plan:
- Reset with RESET_VALUE=0x5A, then read all addresses on both ports -> 0x5A everywhere except register 0 = 0; debug outputs all 0.
- Write 0x12345678 to r7, then read r7 on both ports next cycle -> 0x12345678. Write 0xFFFF to r0 -> r0 still reads 0.
- BYPASS=1: regWrite=1, writeReg=3, writeData=0xABCD, readReg1=3 in the same cycle -> readData1=0xABCD before the edge. With BYPASS=0 -> the old r3 value.
- Preload rK=K+100, pulse dbgStart, hold dbgReady=1:
  - 32 consecutive beats, addr 0..31, data 0,101..131.
  - dbgLast only on addr 31; dbgDone one cycle after; dbgBusy falls the cycle after that.
- Backpressure: dbgReady low for 3 cycles at addr 5 -> dbgValid held, dbgAddr=5 stable. Write r5=0x77 during the stall -> beat 5 accepted with 0x77. Second dbgStart mid-dump -> no restart.
- Assert reset at beat 10 -> dbgValid/dbgBusy low immediately (asynchronous), no dbgDone, registers at RESET_VALUE. A new dbgStart restarts from addr 0.
